// File: rtl/axi4_lite_master_engine.sv
// Single-outstanding AXI4-Lite initiator: one local command becomes one AW/W/B or AR/R transaction.
// Optional wait-cycle watchdog is built when AXI4L_MASTER_TIMEOUT_EN is defined.
module axi4_lite_master_engine #(
  parameter logic [3:0]  AWCACHE_VAL    = 4'h2,
  parameter logic [3:0]  ARCACHE_VAL    = 4'h2,
  parameter logic [2:0]  PROT_VAL       = 3'b000,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  input  logic [3:0]  cmd_wstrb,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_write,
  output logic [31:0] rsp_rdata,
  output logic [1:0]  rsp_resp,
  output logic [31:0] m_awaddr,
  output logic [3:0]  m_awcache,
  output logic [2:0]  m_awprot,
  output logic        m_awvalid,
  input  logic        m_awready,
  output logic [31:0] m_wdata,
  output logic [3:0]  m_wstrb,
  output logic        m_wvalid,
  input  logic        m_wready,
  input  logic [1:0]  m_bresp,
  input  logic        m_bvalid,
  output logic        m_bready,
  output logic [31:0] m_araddr,
  output logic [3:0]  m_arcache,
  output logic [2:0]  m_arprot,
  output logic        m_arvalid,
  input  logic        m_arready,
  input  logic [31:0] m_rdata,
  input  logic [1:0]  m_rresp,
  input  logic        m_rvalid,
  output logic        m_rready,
  output logic        timeout_err
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_WR   = 3'd1;
  localparam logic [2:0] S_WB   = 3'd2;
  localparam logic [2:0] S_RA   = 3'd3;
  localparam logic [2:0] S_RD   = 3'd4;
  localparam logic [2:0] S_RSP  = 3'd5;

  logic [2:0] state;
  logic       aw_done;
  logic       w_done;
  logic       aw_fire;
  logic       w_fire;

  assign aw_fire = m_awvalid & m_awready;
  assign w_fire  = m_wvalid & m_wready;

  assign m_awcache = AWCACHE_VAL;
  assign m_arcache = ARCACHE_VAL;
  assign m_awprot  = PROT_VAL;
  assign m_arprot  = PROT_VAL;

  // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state     <= S_IDLE;
      aw_done   <= 1'b0;
      w_done    <= 1'b0;
      cmd_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_write <= 1'b0;
      rsp_rdata <= '0;
      rsp_resp  <= '0;
      m_awaddr  <= '0;
      m_awvalid <= 1'b0;
      m_wdata   <= '0;
      m_wstrb   <= '0;
      m_wvalid  <= 1'b0;
      m_bready  <= 1'b0;
      m_araddr  <= '0;
      m_arvalid <= 1'b0;
      m_rready  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          cmd_ready <= 1'b1;
          if (cmd_valid && cmd_ready) begin
            cmd_ready <= 1'b0;
            if (cmd_write) begin
              m_awaddr  <= cmd_addr;
              m_wdata   <= cmd_wdata;
              m_wstrb   <= cmd_wstrb;
              m_awvalid <= 1'b1;
              m_wvalid  <= 1'b1;
              aw_done   <= 1'b0;
              w_done    <= 1'b0;
              state     <= S_WR;
            end else begin
              m_araddr  <= cmd_addr;
              m_arvalid <= 1'b1;
              state     <= S_RA;
            end
          end
        end

        // AW and W complete independently, in either order or together.
        S_WR: begin
          if (aw_fire) begin
            m_awvalid <= 1'b0;
            aw_done   <= 1'b1;
          end
          if (w_fire) begin
            m_wvalid <= 1'b0;
            w_done   <= 1'b1;
          end
          if ((aw_done || aw_fire) && (w_done || w_fire)) begin
            m_bready <= 1'b1;
            state    <= S_WB;
          end
        end

        S_WB: begin
          if (m_bvalid) begin
            rsp_resp  <= m_bresp;
            rsp_rdata <= '0;
            rsp_write <= 1'b1;
            rsp_valid <= 1'b1;
            m_bready  <= 1'b0;
            state     <= S_RSP;
          end
        end

        S_RA: begin
          if (m_arready) begin
            m_arvalid <= 1'b0;
            m_rready  <= 1'b1;
            state     <= S_RD;
          end
        end

        S_RD: begin
          if (m_rvalid) begin
            rsp_rdata <= m_rdata;
            rsp_resp  <= m_rresp;
            rsp_write <= 1'b0;
            rsp_valid <= 1'b1;
            m_rready  <= 1'b0;
            state     <= S_RSP;
          end
        end

        S_RSP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= S_IDLE;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef AXI4L_MASTER_TIMEOUT_EN
  localparam logic [15:0] TIMEOUT_LIM = 16'(TIMEOUT_CYCLES);

  logic [15:0] wait_cnt;
  logic        waiting;

  assign waiting = (state == S_WR) || (state == S_WB) || (state == S_RA) || (state == S_RD);

  // Watchdog only flags; the transaction keeps running with unchanged AXI signalling.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      wait_cnt    <= '0;
      timeout_err <= 1'b0;
    end else if (!waiting) begin
      wait_cnt <= '0;
    end else if (wait_cnt != TIMEOUT_LIM) begin
      wait_cnt <= wait_cnt + 16'd1;
      if (wait_cnt + 16'd1 == TIMEOUT_LIM) timeout_err <= 1'b1;
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign timeout_err    = 1'b0;
`endif

endmodule

// File: doc/axi4_lite_master_engine.md
Name: axi4_lite_master_engine

Overview:
Synthesizable AXI4-Lite initiator that turns single-beat commands from a local command/response port into AXI4-Lite write or read transactions on a 32-bit bus.
- Drives the slave-side ports of our AXI4-Lite slave models and DUT slaves; used in loopback benches and as the front end of DPI-driven scenario masters.
- One outstanding transaction at a time; no bursts; 32-bit data only.

Parameters:
- AWCACHE_VAL, 4'h2, constant driven on m_awcache.
- ARCACHE_VAL, 4'h2, constant driven on m_arcache.
- PROT_VAL, 3'b000, constant driven on m_awprot and m_arprot.
- TIMEOUT_CYCLES, 1024, wait-cycle limit; used only when AXI4L_MASTER_TIMEOUT_EN is defined; range 1..65535.

Ports:
- aclk  in  1  clock; all logic on rising edge.
- aresetn  in  1  reset, synchronous, active-low.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  32  byte address, passed through unaligned.
- cmd_wdata  in  32  write data.
- cmd_wstrb  in  4  write strobes; 4'h0 is legal and passed through.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumed when rsp_valid & rsp_ready.
- rsp_write  out  1  echo of cmd_write.
- rsp_rdata  out  32  read data; 0 for writes.
- rsp_resp  out  2  BRESP or RRESP.
- m_awaddr out 32, m_awcache out 4, m_awprot out 3, m_awvalid out 1, m_awready in 1
- m_wdata out 32, m_wstrb out 4, m_wvalid out 1, m_wready in 1
- m_bresp in 2, m_bvalid in 1, m_bready out 1
- m_araddr out 32, m_arcache out 4, m_arprot out 3, m_arvalid out 1, m_arready in 1
- m_rdata in 32, m_rresp in 2, m_rvalid in 1, m_rready out 1
- timeout_err  out  1  sticky wait-timeout flag; tied 0 when the feature is out.

Behaviour:
- Reset: the following outputs are 0 on the edge where aresetn = 0 and stay 0 while it is low: all valids/readies, cmd_ready, rsp_valid, rsp_resp, rsp_rdata, m_awaddr, m_wdata, m_wstrb, m_araddr, timeout_err. FSM goes to IDLE.
- Reset taken mid-transaction abandons it. No response is produced.
- All outputs are registered. The cache/prot constant outputs are always driven.
- FSM states: IDLE, WR (address and data phase), WB (write response), RA (read address), RD (read data), RSP.
- IDLE: cmd_ready = 1.
  - On accept with cmd_write = 1: latch addr, data and strb; next cycle m_awvalid = 1 and m_wvalid = 1; go to WR.
  - On accept with cmd_write = 0: next cycle m_arvalid = 1; go to RA.
- Latency: a command accepted at edge N has its valid asserted in cycle N+1.
- WR: AW and W are tracked by independent done flags.
  - m_awvalid drops on the edge where m_awready is sampled high; m_wvalid likewise with m_wready.
  - Either channel may complete first, or both in the same cycle.
  - When both flags are set, go to WB.
  - Address, data and strb stay stable while the matching valid is high.
- WB: m_bready = 1.
  - On m_bvalid: capture m_bresp, set rsp_rdata = 0 and rsp_write = 1, drop m_bready, go to RSP.
  - m_bvalid arriving before WR completes is ignored; m_bready stays 0 until WB.
- RA: m_arvalid is held until m_arready; then drop it and go to RD.
- RD: m_rready = 1.
  - On m_rvalid: capture m_rdata and m_rresp, set rsp_write = 0, drop m_rready, go to RSP.
- RSP: rsp_valid = 1 with stable fields until rsp_ready. On the handshake edge, rsp_valid goes to 0 and the FSM returns to IDLE.
  - cmd_ready reasserts in the cycle after the handshake.
  - No command is accepted while in RSP, so there is no same-cycle pipelining.
- Minimum turnaround with all slave readies/valids immediate:
  - Write: cmd at N, AW/W handshake at N+1, B at N+2, rsp_valid at N+3.
  - Read: the same timing.

Optional Feature:
- Macro: AXI4L_MASTER_TIMEOUT_EN.
- When defined:
  - A 16-bit wait counter clears in IDLE and RSP and increments every cycle in WR, WB, RA and RD.
  - It saturates at TIMEOUT_CYCLES. On reaching it, timeout_err is set and held until reset.
  - The transaction is not aborted and AXI signalling is unchanged.
- When undefined: no counter is built and timeout_err is a constant 0.

Test Plan:
- Write 0x1000 / 0xDEADBEEF / strb 4'hF with slave readies and bvalid immediate (bresp 2'b00) -> AW/W handshake at N+1, bready at N+2, rsp_valid at N+3 with rsp_write = 1 and rsp_resp = 2'b00.
- Write 0x2004 where m_wready comes 3 cycles before m_awready and m_bvalid is high early -> wvalid drops first; bready stays low until awready; exactly one response.
- Read 0x3000 with arready delayed 2 cycles, rvalid with rdata 0x12345678 and rresp 2'b10 -> rsp_rdata = 0x12345678, rsp_resp = 2'b10, rsp_write = 0.
- Back-to-back write then read, with rsp_ready held low for 4 cycles -> response fields stable; cmd_ready low until the cycle after the rsp handshake; second command issues correctly.
- aresetn low for 1 cycle while in WB -> all outputs 0 next edge; FSM IDLE; no rsp_valid; a new read completes normally.
- With AXI4L_MASTER_TIMEOUT_EN defined and TIMEOUT_CYCLES = 8, slave never asserts arready -> timeout_err = 1 in the cycle after 8 RA cycles; m_arvalid still 1. Without the macro, timeout_err stays 0.
